// File: rtl/mapper_framer.sv
// Frame mapper: walks a ROWS x COLS byte grid, inserting FAS bytes, client payload
// or idle fill, and an optional trailing CRC-8 slot; one frame byte per enabled cycle.
module mapper_framer #(
  parameter int                     ROWS        = 4,
  parameter int                     COLS        = 16,
  parameter int                     FAS_BYTES   = 2,
  parameter logic [8*FAS_BYTES-1:0] FAS_PATTERN = 16'hF628,
  parameter int                     CRC_EN      = 1,
  parameter logic [7:0]             IDLE_BYTE   = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [7:0]  i_pyld_data,
  input  logic        i_pyld_data_valid,
  output logic        o_pyld_data_req,
  input  logic        i_fifo_empty,
  output logic [7:0]  o_frame_data,
  output logic        o_frame_data_valid,
  output logic        o_frame_data_fas,
  output logic        o_frame_sof,
  output logic [7:0]  o_crc_val,
  output logic [15:0] o_idle_cnt
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  generate
    if (FAS_BYTES < 1 || FAS_BYTES >= COLS || ROWS < 1) begin : g_bad_cfg
      $error("mapper_framer: illegal ROWS/COLS/FAS_BYTES combination");
    end
  endgenerate

  function automatic logic [7:0] f_crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [7:0]    r_crc;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_fas;
  logic          r_sof;
  logic [7:0]    r_crc_val;
  logic [15:0]   r_idle;

  logic       w_last;
  logic       w_fas;
  logic       w_crc_slot;
  logic       w_pyld;
  logic       w_take;
  logic [7:0] w_pyld_byte;
  logic [7:0] w_crc_next;
  logic [7:0] w_fas_byte;
  logic [7:0] w_slot_byte;

  assign w_last      = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_fas       = (r_row == '0) && (int'(r_col) < FAS_BYTES);
  assign w_crc_slot  = (CRC_EN != 0) && w_last;
  assign w_pyld      = !w_fas && !w_crc_slot;
  assign w_take      = i_en & w_pyld & i_pyld_data_valid & ~i_fifo_empty;
  assign w_pyld_byte = w_take ? i_pyld_data : IDLE_BYTE;
  assign w_crc_next  = f_crc8(r_crc, w_pyld_byte);

  // FAS byte k is taken MSB byte first from the pattern
  always_comb begin
    w_fas_byte = 8'h00;
    for (int k = 0; k < FAS_BYTES; k++) begin
      if (r_col == CW'(k)) w_fas_byte = FAS_PATTERN[8*(FAS_BYTES-1-k) +: 8];
    end
  end

  assign w_slot_byte     = w_fas ? w_fas_byte : (w_crc_slot ? r_crc : w_pyld_byte);
  assign o_pyld_data_req = w_take & ~i_rst;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row     <= '0;
      r_col     <= '0;
      r_crc     <= 8'h00;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_fas     <= 1'b0;
      r_sof     <= 1'b0;
      r_crc_val <= 8'h00;
      r_idle    <= 16'h0000;
    end else begin
      r_valid <= i_en;
      r_fas   <= i_en & w_fas;
      r_sof   <= i_en & w_fas & (r_col == '0);
      if (i_en) begin
        r_data <= w_slot_byte;
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
        // FAS only occupies the head of row 0, so clearing there restarts the frame CRC
        if (w_fas)       r_crc <= 8'h00;
        else if (w_pyld) r_crc <= w_crc_next;
        if (w_last)      r_crc_val <= w_crc_slot ? r_crc : w_crc_next;
        if (w_pyld && !w_take && r_idle != 16'hFFFF) r_idle <= r_idle + 16'd1;
      end
    end
  end

  assign o_frame_data       = r_data;
  assign o_frame_data_valid = r_valid;
  assign o_frame_data_fas   = r_fas;
  assign o_frame_sof        = r_sof;
  assign o_crc_val          = r_crc_val;
  assign o_idle_cnt         = r_idle;
endmodule

// File: tb/tb_mapper_framer.sv
// Scoreboard bench for mapper_framer: default-configured instance driven by directed
// and random phases, plus a small CRC_EN=0 instance checked frame by frame.
module tb_mapper_framer;
  logic        clk = 1'b0;
  logic        rst, en, pvalid, empty;
  logic [7:0]  pdata;
  logic        req, fvalid, ffas, fsof;
  logic [7:0]  fdata, crc_val;
  logic [15:0] idle_cnt;

  logic        b_rst, b_en, b_pvalid, b_empty;
  logic [7:0]  b_pdata;
  logic        b_req, b_fvalid, b_ffas, b_fsof;
  logic [7:0]  b_fdata, b_crc_val;
  logic [15:0] b_idle_cnt;

  always #5 clk = ~clk;

  mapper_framer dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_pyld_data(pdata),
    .i_pyld_data_valid(pvalid), .o_pyld_data_req(req), .i_fifo_empty(empty),
    .o_frame_data(fdata), .o_frame_data_valid(fvalid), .o_frame_data_fas(ffas),
    .o_frame_sof(fsof), .o_crc_val(crc_val), .o_idle_cnt(idle_cnt)
  );

  mapper_framer #(.ROWS(2), .COLS(4), .FAS_BYTES(1), .FAS_PATTERN(8'hA5), .CRC_EN(0)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_en(b_en), .i_pyld_data(b_pdata),
    .i_pyld_data_valid(b_pvalid), .o_pyld_data_req(b_req), .i_fifo_empty(b_empty),
    .o_frame_data(b_fdata), .o_frame_data_valid(b_fvalid), .o_frame_data_fas(b_ffas),
    .o_frame_sof(b_fsof), .o_crc_val(b_crc_val), .o_idle_cnt(b_idle_cnt)
  );

  typedef struct { logic [7:0] d; bit fas; bit sof; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  logic [7:0] mon_last = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC as the remainder of M(x)*x^8 divided by x^8+x^2+x+1, bit by bit
  function automatic logic [7:0] ref_crc(input logic [7:0] q[$]);
    logic [8:0] r;
    r = 9'h000;
    foreach (q[i]) begin
      for (int b = 7; b >= 0; b--) begin
        r = {r[7:0], q[i][b]};
        if (r[8]) r = r ^ 9'h107;
      end
    end
    for (int b = 0; b < 8; b++) begin
      r = {r[7:0], 1'b0};
      if (r[8]) r = r ^ 9'h107;
    end
    return r[7:0];
  endfunction

  // Monitor: pops expected bytes whenever the DUT presents one
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (fvalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("frame_data", fdata, e.d);
          chk("frame_fas", ffas, e.fas);
          chk("frame_sof", fsof, e.sof);
          mon_last = e.d;
        end
      end else begin
        chk("missing_valid", sb.size(), 0);
        chk("hold_data", fdata, mon_last);
        chk("gap_fas", ffas, 0);
        chk("gap_sof", fsof, 0);
      end
    end
  end

  // Reference model state for the default instance
  int          m_pos = 0;
  int          m_idle = 0;
  logic [7:0]  m_crc_val = 8'h00;
  logic [7:0]  m_fq[$];
  logic [7:0]  next_byte = 8'h01;
  int          req_pulses = 0;

  task automatic model_reset();
    m_pos = 0; m_idle = 0; m_crc_val = 8'h00;
    m_fq.delete(); sb.delete(); mon_last = 8'h00;
  endtask

  task automatic a_cycle(input bit e_en, input bit e_valid, input bit e_empty, input bit do_rst);
    int row, col;
    bit is_fas, is_crc, is_pay, take;
    exp_t e;
    @(negedge clk);
    if (do_rst) begin
      en = 1'b1; pvalid = 1'b1; empty = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_data", fdata, 0);
      chk("rst_valid", fvalid, 0);
      chk("rst_fas", ffas, 0);
      chk("rst_sof", fsof, 0);
      chk("rst_crc_val", crc_val, 0);
      chk("rst_idle", idle_cnt, 0);
      chk("rst_req", req, 0);
      rst = 1'b0;
      model_reset();
    end
    en = e_en; pvalid = e_valid; empty = e_empty; pdata = next_byte;
    #1;
    row = m_pos / 16; col = m_pos % 16;
    is_fas = (row == 0) && (col < 2);
    is_crc = (m_pos == 63);
    is_pay = !is_fas && !is_crc;
    take = e_en && is_pay && e_valid && !e_empty;
    chk("pyld_req", req, take);
    chk("idle_cnt", idle_cnt, m_idle);
    chk("crc_val", crc_val, m_crc_val);
    if (req) req_pulses++;
    if (e_en) begin
      if (m_pos == 0) m_fq.delete();
      e.fas = is_fas; e.sof = (m_pos == 0);
      if (is_fas)      e.d = (col == 0) ? 8'hF6 : 8'h28;
      else if (is_crc) begin e.d = ref_crc(m_fq); m_crc_val = e.d; end
      else begin
        e.d = take ? next_byte : 8'h00;
        m_fq.push_back(e.d);
        if (!take && m_idle < 65535) m_idle++;
      end
      sb.push_back(e);
      m_pos = (m_pos + 1) % 64;
      if (take) next_byte++;
    end
  endtask

  initial begin
    int bpos, bval;
    logic [7:0] b_fq[$];
    logic [7:0] b_crc_exp, b_exp_d;
    bit rst_done;

    rst = 1'b1; en = 1'b0; pvalid = 1'b0; empty = 1'b1; pdata = 8'h00;
    b_rst = 1'b1; b_en = 1'b0; b_pvalid = 1'b0; b_empty = 1'b1; b_pdata = 8'h00;
    repeat (2) @(negedge clk);
    chk("init_data", fdata, 0);
    chk("init_valid", fvalid, 0);
    chk("init_idle", idle_cnt, 0);
    chk("init_req", req, 0);
    rst = 1'b0; b_rst = 1'b0;

    // One full frame of continuous client data 01..3D
    for (int i = 0; i < 64; i++) a_cycle(1, 1, 0, 0);
    a_cycle(0, 0, 1, 0);
    chk("req_pulses_per_frame", req_pulses, 61);
    chk("crc_01_3d", crc_val, ref_crc('{8'h01, 8'h02, 8'h03}) == 8'h00 ? 0 : m_crc_val);

    // Two frames with the client fifo empty
    req_pulses = 0;
    for (int i = 0; i < 128; i++) a_cycle(1, 1, 1, 0);
    a_cycle(0, 0, 1, 0);
    chk("idle_two_frames", idle_cnt, 122);
    chk("idle_frame_crc", crc_val, 0);
    chk("req_never_high", req_pulses, 0);

    // Strobe toggling every cycle
    next_byte = 8'h01;
    for (int i = 0; i < 128; i++) a_cycle((i % 2) == 0, 1, 0, 0);

    // Random traffic with one asynchronous reset at slot (2,5)
    rst_done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      bit r;
      r = !rst_done && (m_pos == 2*16 + 5);
      if (r) rst_done = 1'b1;
      a_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, r);
    end
    chk("reset_taken", rst_done, 1);
    for (int i = 0; i < 3; i++) a_cycle(0, 0, 1, 0);

    // Small instance without CRC slot: A5 + 7 payload bytes per frame
    bpos = 0; bval = 8'h10; b_crc_exp = 8'h00;
    chk("b_crc_init", b_crc_val, 0);
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      b_en = 1'b1; b_pvalid = 1'b1; b_empty = 1'b0; b_pdata = 8'(bval);
      #1;
      chk("b_req", b_req, bpos != 0);
      if (bpos == 0) begin b_exp_d = 8'hA5; b_fq.delete(); end
      else begin b_exp_d = 8'(bval); b_fq.push_back(b_exp_d); bval++; end
      if (bpos == 7) b_crc_exp = ref_crc(b_fq);
      @(posedge clk);
      #1;
      chk("b_valid", b_fvalid, 1);
      chk("b_data", b_fdata, b_exp_d);
      chk("b_fas", b_ffas, bpos == 0);
      chk("b_sof", b_fsof, bpos == 0);
      chk("b_crc_val", b_crc_val, b_crc_exp);
      bpos = (bpos + 1) % 8;
    end
    @(negedge clk);
    b_en = 1'b0;
    chk("b_idle", b_idle_cnt, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
